vec_out_streamer: RTL



---
 rtl/vec_out_streamer_pkg.sv | 25 ++
 rtl/vec_out_streamer_if.sv | 30 +++
 rtl/vec_out_streamer_fifo.sv | 74 +++++++
 rtl/vec_out_streamer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/vec_out_streamer_pkg.sv
// Shared widths, unpacker state type and the output-window decode for the vector output streamer.
package audio_simd_pkg;

    localparam int VEC_W      = 128;
    localparam int LANE_W     = 32;
    localparam int LANES      = 4;
    localparam int LANE_IDX_W = 2;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    // Compare only the address bits above the window size.
    function automatic logic win_hit(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int          win_bits
    );
        logic [31:0] mask_v;
        mask_v  = 32'hFFFF_FFFF << win_bits;
        win_hit = ((addr & mask_v) == (base & mask_v));
    endfunction

endpackage

// File: rtl/vec_out_streamer_if.sv
// Store-snoop bus, sample stream and status signals of the vector output streamer.
interface vec_out_streamer_if
    import audio_simd_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              wr_en;
    logic [31:0]       wr_addr;
    logic [VEC_W-1:0]  wr_data;
    logic [LANE_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;
    logic [CNT_W-1:0]  fifo_count;
    logic              busy;
    logic              overflow;
    logic              clr_ovf;

    modport master (
        input  wr_en, wr_addr, wr_data, sample_ready, clr_ovf,
        output sample_data, sample_valid, fifo_count, busy, overflow
    );

    modport slave (
        output wr_en, wr_addr, wr_data, sample_ready, clr_ovf,
        input  sample_data, sample_valid, fifo_count, busy, overflow
    );

endinterface

// File: rtl/vec_out_streamer_fifo.sv
// 128-bit synchronous FIFO; a push into a full FIFO is still taken when a pop frees the slot on the same edge.
module vec_fifo
    import audio_simd_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [VEC_W-1:0] push_data,
    input  logic             pop,
    output logic [VEC_W-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nx
);

    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [VEC_W-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head  = mem_r[rd_ptr_r[AW-1:0]];
    assign count = count_r;

    // Qualify requests and derive the next occupancy
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        if (do_push_s && !do_pop_s) begin
            count_nx = count_r + CNT_ONE;
        end else if (!do_push_s && do_pop_s) begin
            count_nx = count_r - CNT_ONE;
        end else begin
            count_nx = count_r;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nx;
        end
    end

    // Storage array; contents are meaningless until written so it carries no reset
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/vec_out_streamer.sv
// Captures vector stores that hit the output window and streams them out as 32-bit lanes, lane 0 first.
module vec_out_streamer
    import audio_simd_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          WIN_BITS  = 12
) (
    input  logic               clk,
    input  logic               reset,
    vec_out_streamer_if.master bus
);

    localparam int                   CNT_W     = $clog2(DEPTH + 1);
    localparam logic [LANE_IDX_W-1:0] LAST_LANE = 2'b11;
    localparam logic [LANE_IDX_W-1:0] LANE_ONE  = 2'b01;

    stream_state_t         state_r;
    stream_state_t         state_nx_s;
    logic [LANE_IDX_W-1:0] lane_r;
    logic [LANE_IDX_W-1:0] lane_nx_s;
    logic [VEC_W-1:0]      hold_r;
    logic [VEC_W-1:0]      hold_nx_s;
    logic [LANE_W-1:0]     sample_data_r;
    logic [LANE_W-1:0]     sample_nx_s;
    logic                  sample_valid_r;
    logic                  valid_nx_s;
    logic                  busy_r;
    logic                  overflow_r;
    logic                  ovf_nx_s;
    logic                  hit_s;
    logic                  drop_s;
    logic                  pop_s;
    logic                  xfer_s;
    logic [VEC_W-1:0]      fifo_head_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic [CNT_W-1:0]      fifo_count_nx_s;

    assign hit_s  = bus.wr_en & win_hit(bus.wr_addr, BASE_ADDR, WIN_BITS);
    assign drop_s = hit_s & fifo_full_s & ~pop_s;

    vec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (hit_s),
        .push_data (bus.wr_data),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .count_nx  (fifo_count_nx_s)
    );

    // Unpacker next state: load on idle, advance lanes, refill with no bubble after lane 3
    always_comb begin
        state_nx_s = state_r;
        lane_nx_s  = lane_r;
        hold_nx_s  = hold_r;
        valid_nx_s = sample_valid_r;
        pop_s      = 1'b0;
        xfer_s     = sample_valid_r & bus.sample_ready;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    hold_nx_s  = fifo_head_s;
                    lane_nx_s  = '0;
                    valid_nx_s = 1'b1;
                    state_nx_s = STREAM;
                end else begin
                    valid_nx_s = 1'b0;
                end
            end
            STREAM: begin
                if (xfer_s && (lane_r != LAST_LANE)) begin
                    lane_nx_s = lane_r + LANE_ONE;
                end else if (xfer_s && !fifo_empty_s) begin
                    pop_s     = 1'b1;
                    hold_nx_s = fifo_head_s;
                    lane_nx_s = '0;
                end else if (xfer_s) begin
                    lane_nx_s  = '0;
                    valid_nx_s = 1'b0;
                    state_nx_s = IDLE;
                end else begin
                    lane_nx_s = lane_r;
                end
            end
            default: begin
                lane_nx_s  = '0;
                valid_nx_s = 1'b0;
                state_nx_s = IDLE;
            end
        endcase
        if (valid_nx_s) begin
            sample_nx_s = hold_nx_s[lane_nx_s * LANE_W +: LANE_W];
        end else begin
            sample_nx_s = sample_data_r;
        end
    end

    // Sticky drop flag; a new drop beats a clear on the same edge
    always_comb begin
        if (drop_s) begin
            ovf_nx_s = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_nx_s = 1'b0;
        end else begin
            ovf_nx_s = overflow_r;
        end
    end

    // Unpacker state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            lane_r         <= '0;
            hold_r         <= '0;
            sample_data_r  <= '0;
            sample_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            overflow_r     <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            lane_r         <= lane_nx_s;
            hold_r         <= hold_nx_s;
            sample_data_r  <= sample_nx_s;
            sample_valid_r <= valid_nx_s;
            busy_r         <= (state_nx_s == STREAM) | (fifo_count_nx_s != '0);
            overflow_r     <= ovf_nx_s;
        end
    end

    assign bus.sample_data  = sample_data_r;
    assign bus.sample_valid = sample_valid_r;
    assign bus.fifo_count   = fifo_count_s;
    assign bus.busy         = busy_r;
    assign bus.overflow     = overflow_r;

endmodule
